// File: rtl/sm_reg_dump_pkg.sv
// Shared types for the schoolMIPS debug register dump reader.
// State encoding and bus widths used by sm_reg_dump.
package sm_reg_dump_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    typedef enum logic [1:0] {
        SM_RD_IDLE  = 2'd0,
        SM_RD_SETUP = 2'd1,
        SM_RD_SEND  = 2'd2,
        SM_RD_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sm_reg_dump.sv
// Walks the core debug register port over a range and streams each
// captured word out over valid/ready, tagged with its register index.
module sm_reg_dump
    import sm_reg_dump_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [REG_AW-1:0] regAddr,
    input  logic [REG_DW-1:0] regData,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_index,
    output logic [REG_DW-1:0] out_data,
    output logic              out_last
);

    localparam logic [REG_AW-1:0] FIRST_IDX = FIRST_REG[REG_AW-1:0];
    localparam logic [REG_AW-1:0] LAST_IDX  = LAST_REG[REG_AW-1:0];

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [REG_AW-1:0] idx;
    logic [REG_AW-1:0] idx_nxt;
    logic              capture;
    logic              accept;
    logic              at_last;

    assign accept  = (state == SM_RD_SEND) && out_ready;
    assign at_last = (idx == LAST_IDX);

    // abort overrides every transition, including start in IDLE
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        capture   = 1'b0;
        unique case (state)
            SM_RD_IDLE: begin
                if (start) begin
                    state_nxt = SM_RD_SETUP;
                    idx_nxt   = FIRST_IDX;
                end
            end
            SM_RD_SETUP: begin
                capture   = 1'b1;
                state_nxt = SM_RD_SEND;
            end
            SM_RD_SEND: begin
                if (accept) begin
                    if (at_last) begin
                        state_nxt = SM_RD_DONE;
                    end else begin
                        state_nxt = SM_RD_SETUP;
                        idx_nxt   = idx + 5'd1;
                    end
                end
            end
            SM_RD_DONE: begin
                state_nxt = SM_RD_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = SM_RD_IDLE;
            idx_nxt   = idx;
            capture   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SM_RD_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // the word is frozen from SETUP until the next SETUP, so stalls hold it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_index <= '0;
        end else if (capture) begin
            out_data  <= regData;
            out_index <= idx;
        end
    end

    assign regAddr   = idx;
    assign busy      = (state != SM_RD_IDLE);
    assign done      = (state == SM_RD_DONE);
    assign out_valid = (state == SM_RD_SEND);
    assign out_last  = out_valid && (out_index == LAST_IDX);

endmodule

// File: tb/tb_sm_reg_dump.sv
// Randomized self-checking bench for sm_reg_dump against a model core
// register file and a sequence-level reference of the expected stream.
module tb_sm_reg_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_index;
    logic [31:0] out_data;
    logic        out_last;

    logic        start4;
    logic        abort4;
    logic        busy4;
    logic        done4;
    logic [4:0]  regAddr4;
    logic [31:0] regData4;
    logic        out_valid4;
    logic        ready4;
    logic [4:0]  out_index4;
    logic [31:0] out_data4;
    logic        out_last4;

    logic [31:0] core_r [32];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign regData  = core_r[regAddr];
    assign regData4 = core_r[regAddr4];

    sm_reg_dump #(.FIRST_REG(0), .LAST_REG(31)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .busy(busy), .done(done), .regAddr(regAddr), .regData(regData),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data), .out_last(out_last)
    );

    sm_reg_dump #(.FIRST_REG(4), .LAST_REG(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .abort(abort4),
        .busy(busy4), .done(done4), .regAddr(regAddr4), .regData(regData4),
        .out_valid(out_valid4), .out_ready(ready4),
        .out_index(out_index4), .out_data(out_data4), .out_last(out_last4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one dump on dut starting at the current negedge.
    // mode 0: ready always high, 1: ready pattern 0,0,1, 2: random ready.
    task automatic dump(input int mode, input bit hold, output int dcyc,
                        output int nacc);
        bit          pend;
        logic [31:0] pd;
        logic [4:0]  pi;
        logic        pl;
        int          e;
        pend  = 1'b0;
        nacc  = 0;
        dcyc  = -1;
        start = 1'b1;
        out_ready = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (c == 1) begin
                chk("setup_no_valid", out_valid, 1'b0);
                chk("setup_addr", regAddr, 0);
            end
            if (pend) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_index", out_index, pi);
                chk("stall_data", out_data, pd);
                chk("stall_last", out_last, pl);
            end
            chk("busy_in_dump", busy, 1'b1);
            if (done) begin
                dcyc = c;
                break;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c % 3 == 1);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            pend = 1'b0;
            if (out_valid && out_ready) begin
                e = nacc;
                chk("word_index", out_index, e);
                chk("word_data", out_data, core_r[e]);
                chk("word_last", out_last, (e == 31));
                nacc++;
            end else if (out_valid) begin
                pend = 1'b1;
                pi = out_index;
                pd = out_data;
                pl = out_last;
            end
        end
        out_ready = 1'b0;
        if (dcyc < 0) chk("dump_timeout", 0, 1);
        chk("word_count", nacc, 32);
    endtask

    initial begin
        int  dc;
        int  na;
        int  acc_c;
        int  cnt;
        bit  hit;

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        start4 = 1'b0; abort4 = 1'b0; ready4 = 1'b0;
        core_r[0] = 32'h40;
        for (int i = 1; i < 32; i++) core_r[i] = 32'h100 + i;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_addr", regAddr, 0);
        chk("rst_index", out_index, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;
        @(negedge clk);

        dump(0, 1'b0, dc, na);
        chk("full_done_cycle", dc, 65);
        @(negedge clk);
        chk("idle_after_done", busy, 0);
        chk("done_one_cycle", done, 0);

        dump(1, 1'b0, dc, na);
        @(negedge clk);

        start4 = 1'b1; ready4 = 1'b1; cnt = 0; acc_c = 0; dc = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (done4) begin
                dc = c;
                break;
            end
            if (out_valid4) begin
                cnt++;
                acc_c = c;
                chk("r4_index", out_index4, 4);
                chk("r4_data", out_data4, core_r[4]);
                chk("r4_last", out_last4, 1);
            end
        end
        chk("r4_words", cnt, 1);
        chk("r4_done_cycle", dc, 3);
        chk("r4_done_after_acc", dc - acc_c, 1);
        ready4 = 1'b0;
        @(negedge clk);
        chk("r4_idle", busy4, 0);

        start = 1'b1; out_ready = 1'b1; hit = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_index == 5'd7) begin
                hit = 1'b1;
                abort = 1'b1;
                break;
            end
        end
        chk("abort_reached", hit, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_done_later", done, 0);
        dump(0, 1'b0, dc, na);
        chk("restart_done_cycle", dc, 65);
        @(negedge clk);

        dump(0, 1'b1, dc, na);
        @(negedge clk);
        chk("held_start_idle", busy, 0);
        dump(0, 1'b1, dc, na);
        start = 1'b0;
        @(negedge clk);

        start = 1'b1; out_ready = 1'b1; hit = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (out_valid && out_index == 5'd12) begin
                hit = 1'b1;
                rst = 1'b1;
                break;
            end
        end
        chk("rst_reached", hit, 1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        chk("mrst_busy", busy, 0);
        chk("mrst_valid", out_valid, 0);
        chk("mrst_last", out_last, 0);
        chk("mrst_addr", regAddr, 0);
        chk("mrst_index", out_index, 0);
        chk("mrst_data", out_data, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mrst_no_done", done, 0);
        end

        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 32; i++) core_r[i] = $urandom;
            dump(2, 1'b0, dc, na);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
